// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the AXI request scheduler.
// The INST/DATA grant encoding doubles as the AXI read ID.
package axi_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW   = 3'd3,
        S_W    = 3'd4,
        S_B    = 3'd5
    } sched_state_e;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [3:0] AXI_ID_INST  = 4'd0;
    localparam logic [3:0] AXI_ID_DATA  = 4'd1;
    localparam logic [3:0] AXI_ID_WRITE = 4'd1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker. last names the side granted most recently
// (0 = req0, 1 = req1), and last_nxt carries the updated value.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic en,
    output logic gnt0,
    output logic gnt1,
    output logic last_nxt
);

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        last_nxt = last;
        if (en) begin
            // On a tie, the side that did not win last time gets the grant.
            if (req0 && req1) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
            if (gnt0) begin
                last_nxt = 1'b0;
            end else if (gnt1) begin
                last_nxt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_req_scheduler.sv
// Shares one AXI master port between the instruction and data requesters.
// Only one AXI transaction is in flight at a time.
module axi_req_scheduler
    import axi_sched_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [LEN_W-1:0]    inst_len,
    output logic                inst_ack,
    output logic                inst_rvalid,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_rlast,

    input  logic                data_req,
    input  logic                data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [LEN_W-1:0]    data_len,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_ack,
    output logic                data_wnext,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_rlast,
    output logic                data_bdone,

    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [LEN_W-1:0]    arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,

    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,

    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [LEN_W-1:0]    awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,

    output logic [3:0]          wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,

    input  logic                bvalid,
    output logic                bready
);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] reqAddr_q, reqAddr_d;
    logic [LEN_W-1:0]  reqLen_q, reqLen_d;
    logic              reqWe_q, reqWe_d;
    logic              grantId_q, grantId_d;
    logic              lastGrant_q, lastGrant_d;
    logic [LEN_W-1:0]  beatCnt_q, beatCnt_d;

    logic pickEn;
    logic gntInst;
    logic gntData;
    logic unused_rid;

    // Read IDs are not checked: only one read is ever outstanding.
    assign unused_rid = ^rid;

    // Gating with rst keeps every ack low while reset is held.
    assign pickEn = (state_q == S_IDLE) && rst;

    rr_pick2 u_pick (
        .req0     (inst_req),
        .req1     (data_req),
        .last     (lastGrant_q),
        .en       (pickEn),
        .gnt0     (gntInst),
        .gnt1     (gntData),
        .last_nxt (lastGrant_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            reqAddr_q   <= '0;
            reqLen_q    <= '0;
            reqWe_q     <= 1'b0;
            grantId_q   <= GRANT_INST;
            lastGrant_q <= GRANT_DATA;
            beatCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            reqAddr_q   <= reqAddr_d;
            reqLen_q    <= reqLen_d;
            reqWe_q     <= reqWe_d;
            grantId_q   <= grantId_d;
            lastGrant_q <= lastGrant_d;
            beatCnt_q   <= beatCnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        reqAddr_d   = reqAddr_q;
        reqLen_d    = reqLen_q;
        reqWe_d     = reqWe_q;
        grantId_d   = grantId_q;
        beatCnt_d   = beatCnt_q;

        inst_ack    = 1'b0;
        inst_rvalid = 1'b0;
        inst_rdata  = '0;
        inst_rlast  = 1'b0;
        data_ack    = 1'b0;
        data_wnext  = 1'b0;
        data_rvalid = 1'b0;
        data_rdata  = '0;
        data_rlast  = 1'b0;
        data_bdone  = 1'b0;

        // Address and length stay on the bus between transactions.
        arid        = '0;
        araddr      = reqAddr_q;
        arlen       = reqLen_q;
        arsize      = '0;
        arburst     = '0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awid        = '0;
        awaddr      = reqAddr_q;
        awlen       = reqLen_q;
        awsize      = '0;
        awburst     = '0;
        awvalid     = 1'b0;
        wid         = '0;
        wdata       = '0;
        wstrb       = '0;
        wlast       = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                inst_ack = gntInst;
                data_ack = gntData;
                if (gntInst || gntData) begin
                    reqAddr_d = gntData ? data_addr : inst_addr;
                    reqLen_d  = gntData ? data_len : inst_len;
                    reqWe_d   = gntData && data_we;
                    grantId_d = gntData ? GRANT_DATA : GRANT_INST;
                    beatCnt_d = '0;
                    state_d   = (gntData && data_we) ? S_AW : S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                arid    = {3'b000, grantId_q};
                arsize  = AXI_SIZE_4B;
                arburst = AXI_BURST_INCR;
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                rready = 1'b1;
                if (grantId_q == GRANT_INST) begin
                    inst_rvalid = rvalid;
                    inst_rdata  = rdata;
                    inst_rlast  = rlast;
                end else begin
                    data_rvalid = rvalid;
                    data_rdata  = rdata;
                    data_rlast  = rlast;
                end
                // An early rlast ends the burst; nothing more is requested.
                if (rvalid && rlast) begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                awid    = AXI_ID_WRITE;
                awsize  = AXI_SIZE_4B;
                awburst = AXI_BURST_INCR;
                if (awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                wvalid     = 1'b1;
                wid        = AXI_ID_WRITE;
                wdata      = data_wdata;
                wstrb      = data_wstrb;
                wlast      = (beatCnt_q == reqLen_q);
                data_wnext = wready && reqWe_q;
                if (wready) begin
                    beatCnt_d = beatCnt_q + LEN_W'(1);
                    if (wlast) begin
                        beatCnt_d = '0;
                        state_d   = S_B;
                    end
                end
            end
            S_B: begin
                bready     = 1'b1;
                data_bdone = bvalid;
                if (bvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
